// File: rtl/nodf_mon_pkg.sv
// Shared types and constants for the non-dataflow ap_* handshake monitor.
// Optional feature macro used by the top: NODF_MON_LATENCY_EN.
package nodf_mon_pkg;

    // Control state of the monitored block as seen from its handshake.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BUSY      = 2'd1,
        ST_DONE_HOLD = 2'd2
    } nodf_state_e;

    // Default width of every statistics counter.
    localparam int DEFAULT_CNT_W = 32;

    // An input only counts as asserted when it is a clean 1; X or Z reads as 0.
    function automatic logic is_high(input logic v);
        return (v === 1'b1);
    endfunction

endpackage : nodf_mon_pkg

// File: rtl/nodf_sat_counter.sv
// Saturating up-counter with synchronous active-high reset and a freeze input.
// Once the counter reaches all-ones it holds there until reset.
module nodf_sat_counter
    import nodf_mon_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             freeze,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Count one per enabled cycle, stop at all-ones, hold while frozen.
    always_ff @(posedge clock) begin
        // NOTE: registered state is always updated with <= so every flop samples
        // pre-edge values; a blocking = here would create order-dependent races.
        if (reset) begin
            q <= '0;
        end else if (inc && !freeze && (q != CNT_MAX)) begin
            q <= q + 1'b1;
        end
    end

endmodule : nodf_sat_counter

// File: rtl/nodf_handshake_monitor.sv
// Status monitor for one non-dataflow HLS block's ap_start/ap_ready/ap_done/
// ap_continue handshake. Tracks the block's control state and keeps saturating
// event/cycle counters that freeze one cycle after 'finish' is first seen.
// Optional feature: define NODF_MON_LATENCY_EN to add lat_min/lat_max/lat_last,
// the start-to-done latency statistics of completed transactions.
module nodf_handshake_monitor
    import nodf_mon_pkg::*;
#(
    parameter int CNT_W        = DEFAULT_CNT_W,
    parameter int HAS_CONTINUE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             finish,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] start_cnt,
    output logic [CNT_W-1:0] ready_cnt,
    output logic [CNT_W-1:0] done_cnt,
    output logic [CNT_W-1:0] busy_cycles,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             finished
`ifdef NODF_MON_LATENCY_EN
    ,
    output logic [CNT_W-1:0] lat_min,
    output logic [CNT_W-1:0] lat_max,
    output logic [CNT_W-1:0] lat_last
`endif
);

    // When continue is not part of the block's protocol it is treated as always 1,
    // so the DONE_HOLD state can never be entered.
    localparam bit USE_CONT = (HAS_CONTINUE != 0);

    // Cleaned-up (X -> 0) versions of the monitored inputs.
    logic start_v;
    logic ready_v;
    logic done_v;
    logic cont_v;
    logic finish_v;

    nodf_state_e state_q;
    nodf_state_e state_d;
    logic        start_acc;   // a start is accepted on this edge
    logic        done_ev;     // a done is observed while busy on this edge

    // Sanitise inputs so that unknown values never count as events.
    always_comb begin
        start_v  = is_high(ap_start);
        ready_v  = is_high(ap_ready);
        done_v   = is_high(ap_done);
        cont_v   = USE_CONT ? is_high(ap_continue) : 1'b1;
        finish_v = is_high(finish);
    end

    // Next-state and event decode for the handshake state machine.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path through
        // the case leaves a value unassigned and no latch is inferred.
        state_d   = state_q;
        start_acc = 1'b0;
        done_ev   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_v) begin
                    state_d   = ST_BUSY;
                    start_acc = 1'b1;
                end
            end
            ST_BUSY: begin
                if (done_v) begin
                    done_ev = 1'b1;
                    if (USE_CONT && !cont_v) begin
                        state_d = ST_DONE_HOLD;
                    end else if (start_v) begin
                        // Back-to-back transaction: stay busy, count the new start.
                        state_d   = ST_BUSY;
                        start_acc = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DONE_HOLD: begin
                // Starts offered while held are neither accepted nor counted.
                if (cont_v) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; holds once the run has finished.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else if (!finished) begin
            state_q <= state_d;
        end
    end

    // Sticky end-of-run flag; only reset clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            finished <= 1'b0;
        end else if (finish_v) begin
            finished <= 1'b1;
        end
    end

    assign state = state_q;

    // Event and occupancy counters. The freeze input is the registered
    // 'finished', so events in the first cycle finish is high still count.
    nodf_sat_counter #(.CNT_W(CNT_W)) u_start_cnt (
        .clock  (clock),
        .reset  (reset),
        .inc    (start_acc),
        .freeze (finished),
        .q      (start_cnt)
    );

    nodf_sat_counter #(.CNT_W(CNT_W)) u_ready_cnt (
        .clock  (clock),
        .reset  (reset),
        .inc    (ready_v),
        .freeze (finished),
        .q      (ready_cnt)
    );

    nodf_sat_counter #(.CNT_W(CNT_W)) u_done_cnt (
        .clock  (clock),
        .reset  (reset),
        .inc    (done_ev),
        .freeze (finished),
        .q      (done_cnt)
    );

    nodf_sat_counter #(.CNT_W(CNT_W)) u_busy_cycles (
        .clock  (clock),
        .reset  (reset),
        .inc    (state_q == ST_BUSY),
        .freeze (finished),
        .q      (busy_cycles)
    );

    nodf_sat_counter #(.CNT_W(CNT_W)) u_stall_cycles (
        .clock  (clock),
        .reset  (reset),
        .inc    (state_q == ST_DONE_HOLD),
        .freeze (finished),
        .q      (stall_cycles)
    );

`ifdef NODF_MON_LATENCY_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Cycles since the accepted start: 1 on the edge after the start, then +1 per
    // busy cycle, so a done sampled k edges after the start reads k.
    logic [CNT_W-1:0] lat_run;

    // Running latency counter and min/max/last statistics, updated on each done.
    always_ff @(posedge clock) begin
        if (reset) begin
            lat_run  <= '0;
            lat_min  <= CNT_MAX;
            lat_max  <= '0;
            lat_last <= '0;
        end else if (!finished) begin
            if (start_acc) begin
                lat_run <= CNT_W'(1);
            end else if ((state_q == ST_BUSY) && (lat_run != CNT_MAX)) begin
                lat_run <= lat_run + 1'b1;
            end
            if (done_ev) begin
                lat_last <= lat_run;
                if (lat_run < lat_min) begin
                    lat_min <= lat_run;
                end
                if (lat_run > lat_max) begin
                    lat_max <= lat_run;
                end
            end
        end
    end
`endif

endmodule : nodf_handshake_monitor

// File: tb/tb_nodf_handshake_monitor.sv
// Self-checking bench for nodf_handshake_monitor. Three instances share one
// stimulus stream: (CNT_W=32, no continue), (CNT_W=32, continue), (CNT_W=4,
// continue). A transaction-level model per instance is compared every cycle,
// and directed scenarios pin the model with hand-computed values.
module tb_nodf_handshake_monitor;

    localparam int NDUT = 3;

    logic clock       = 1'b0;
    logic reset       = 1'b1;
    logic ap_start    = 1'b0;
    logic ap_ready    = 1'b0;
    logic ap_done     = 1'b0;
    logic ap_continue = 1'b1;
    logic finish      = 1'b0;

    always #5 clock = ~clock;

    logic [1:0]  d0_state, d1_state, d2_state;
    logic [31:0] d0_start, d0_ready, d0_done, d0_busy, d0_stall;
    logic [31:0] d1_start, d1_ready, d1_done, d1_busy, d1_stall;
    logic [3:0]  d2_start, d2_ready, d2_done, d2_busy, d2_stall;
    logic        d0_fin, d1_fin, d2_fin;
`ifdef NODF_MON_LATENCY_EN
    logic [31:0] d0_lmin, d0_lmax, d0_llast;
    logic [31:0] d1_lmin, d1_lmax, d1_llast;
    logic [3:0]  d2_lmin, d2_lmax, d2_llast;
`endif

    nodf_handshake_monitor #(.CNT_W(32), .HAS_CONTINUE(0)) u_dut0 (
        .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
        .state(d0_state), .start_cnt(d0_start), .ready_cnt(d0_ready),
        .done_cnt(d0_done), .busy_cycles(d0_busy), .stall_cycles(d0_stall),
        .finished(d0_fin)
`ifdef NODF_MON_LATENCY_EN
        , .lat_min(d0_lmin), .lat_max(d0_lmax), .lat_last(d0_llast)
`endif
    );

    nodf_handshake_monitor #(.CNT_W(32), .HAS_CONTINUE(1)) u_dut1 (
        .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
        .state(d1_state), .start_cnt(d1_start), .ready_cnt(d1_ready),
        .done_cnt(d1_done), .busy_cycles(d1_busy), .stall_cycles(d1_stall),
        .finished(d1_fin)
`ifdef NODF_MON_LATENCY_EN
        , .lat_min(d1_lmin), .lat_max(d1_lmax), .lat_last(d1_llast)
`endif
    );

    nodf_handshake_monitor #(.CNT_W(4), .HAS_CONTINUE(1)) u_dut2 (
        .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
        .state(d2_state), .start_cnt(d2_start), .ready_cnt(d2_ready),
        .done_cnt(d2_done), .busy_cycles(d2_busy), .stall_cycles(d2_stall),
        .finished(d2_fin)
`ifdef NODF_MON_LATENCY_EN
        , .lat_min(d2_lmin), .lat_max(d2_lmax), .lat_last(d2_llast)
`endif
    );

    // ------------------------------------------------------------------
    // Checking infrastructure
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction-level reference model
    // ------------------------------------------------------------------
    typedef struct {
        bit     busy;      // a transaction is in flight
        bit     hold;      // completed, waiting for continue
        bit     fin;       // statistics frozen
        longint start_c;
        longint ready_c;
        longint done_c;
        longint busy_c;
        longint stall_c;
        longint lat_min;
        longint lat_max;
        longint lat_last;
        longint t_start;   // cycle index of the accepted start
    } model_t;

    model_t mdl [NDUT];
    longint cyc    = 0;
    bit     mvalid = 1'b0;

    function automatic longint cmax_of(input int k);
        return (k == 2) ? 64'd15 : 64'd4294967295;
    endfunction

    function automatic bit has_cont_of(input int k);
        return (k != 0);
    endfunction

    function automatic longint bump(input longint v, input longint mx);
        return (v < mx) ? v + 1 : v;
    endfunction

    function automatic model_t model_reset(input int k);
        model_t n;
        n.busy     = 1'b0;
        n.hold     = 1'b0;
        n.fin      = 1'b0;
        n.start_c  = 0;
        n.ready_c  = 0;
        n.done_c   = 0;
        n.busy_c   = 0;
        n.stall_c  = 0;
        n.lat_min  = cmax_of(k);
        n.lat_max  = 0;
        n.lat_last = 0;
        n.t_start  = 0;
        return n;
    endfunction

    function automatic model_t model_step(input model_t m, input int k,
                                          input bit rs, input bit st, input bit rd,
                                          input bit dn, input bit ct, input bit fn,
                                          input longint now);
        model_t n;
        longint mx;
        longint lat;
        mx = cmax_of(k);
        n  = m;
        if (rs) return model_reset(k);
        if (m.fin) return n;
        if (rd) n.ready_c = bump(m.ready_c, mx);
        if (m.busy) begin
            n.busy_c = bump(m.busy_c, mx);
            if (dn) begin
                n.done_c = bump(m.done_c, mx);
                lat = now - m.t_start;
                if (lat > mx) lat = mx;
                n.lat_last = lat;
                if (lat < m.lat_min) n.lat_min = lat;
                if (lat > m.lat_max) n.lat_max = lat;
                if (has_cont_of(k) && !ct) begin
                    n.busy = 1'b0;
                    n.hold = 1'b1;
                end else if (st) begin
                    n.start_c = bump(m.start_c, mx);
                    n.t_start = now;
                end else begin
                    n.busy = 1'b0;
                end
            end
        end else if (m.hold) begin
            n.stall_c = bump(m.stall_c, mx);
            if (ct) n.hold = 1'b0;
        end else if (st) begin
            n.start_c = bump(m.start_c, mx);
            n.busy    = 1'b1;
            n.t_start = now;
        end
        if (fn) n.fin = 1'b1;
        return n;
    endfunction

    // Advance the model on every rising edge with the inputs the DUTs sample.
    always @(posedge clock) begin
        for (int k = 0; k < NDUT; k++) begin
            mdl[k] = model_step(mdl[k], k, reset, ap_start, ap_ready, ap_done,
                                ap_continue, finish, cyc);
        end
        if (reset) mvalid = 1'b1;
        cyc++;
    end

    task automatic compare_dut(input int k, input longint st, input longint sc,
                               input longint rc, input longint dc, input longint bc,
                               input longint sl, input longint fi);
        longint exp_state;
        exp_state = mdl[k].busy ? 1 : (mdl[k].hold ? 2 : 0);
        check($sformatf("dut%0d state", k),        st, exp_state);
        check($sformatf("dut%0d start_cnt", k),    sc, mdl[k].start_c);
        check($sformatf("dut%0d ready_cnt", k),    rc, mdl[k].ready_c);
        check($sformatf("dut%0d done_cnt", k),     dc, mdl[k].done_c);
        check($sformatf("dut%0d busy_cycles", k),  bc, mdl[k].busy_c);
        check($sformatf("dut%0d stall_cycles", k), sl, mdl[k].stall_c);
        check($sformatf("dut%0d finished", k),     fi, longint'(mdl[k].fin));
    endtask

`ifdef NODF_MON_LATENCY_EN
    task automatic compare_lat(input int k, input longint mn, input longint mxv,
                               input longint ls);
        check($sformatf("dut%0d lat_min", k),  mn,  mdl[k].lat_min);
        check($sformatf("dut%0d lat_max", k),  mxv, mdl[k].lat_max);
        check($sformatf("dut%0d lat_last", k), ls,  mdl[k].lat_last);
    endtask
`endif

    // Compare every DUT against the model on each falling edge.
    always @(negedge clock) begin
        if (mvalid) begin
            compare_dut(0, d0_state, d0_start, d0_ready, d0_done, d0_busy, d0_stall, d0_fin);
            compare_dut(1, d1_state, d1_start, d1_ready, d1_done, d1_busy, d1_stall, d1_fin);
            compare_dut(2, d2_state, d2_start, d2_ready, d2_done, d2_busy, d2_stall, d2_fin);
`ifdef NODF_MON_LATENCY_EN
            compare_lat(0, d0_lmin, d0_lmax, d0_llast);
            compare_lat(1, d1_lmin, d1_lmax, d1_llast);
            compare_lat(2, d2_lmin, d2_lmax, d2_llast);
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    // Apply one cycle of inputs, return at the following falling edge.
    task automatic drive(input bit st, input bit rd, input bit dn, input bit ct,
                         input bit fn, input bit rs);
        ap_start    = st;
        ap_ready    = rd;
        ap_done     = dn;
        ap_continue = ct;
        finish      = fn;
        reset       = rs;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        do_reset();
        do_reset();

        // Reset state.
        check("reset state", d0_state, 0);
        check("reset finished", d1_fin, 0);

        // ap_ready only, start tied low.
        do_reset();
        repeat (5) drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("ready-only ready_cnt", d0_ready, 5);
        check("ready-only start_cnt", d0_start, 0);
        check("ready-only state", d0_state, 0);

        // Single transaction, done three edges after start.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("single start_cnt", d0_start, 1);
        check("single done_cnt", d0_done, 1);
        check("single busy_cycles", d0_busy, 3);
        check("single state", d0_state, 0);
`ifdef NODF_MON_LATENCY_EN
        check("single lat_min", d0_lmin, 3);
        check("single lat_max", d0_lmax, 3);
`endif

        // Done while continue low for four cycles, starts offered while held.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("hold entered", d1_state, 2);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("hold stall_cycles", d1_stall, 4);
        check("hold released state", d1_state, 0);
        check("hold start ignored", d1_start, 1);

        // Back-to-back: done and start together twice.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("b2b start_cnt", d0_start, 3);
        check("b2b done_cnt", d0_done, 2);
        check("b2b state", d0_state, 1);
        check("b2b busy_cycles", d0_busy, 2);

        // Saturation of the 4-bit instance.
        do_reset();
        repeat (20) drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("sat ready_cnt", d2_ready, 15);
        repeat (2) drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("sat ready_cnt holds", d2_ready, 15);
        check("wide ready_cnt", d0_ready, 22);

        // Finish mid-transaction, then more activity, then reset.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("finish finished", d0_fin, 1);
        check("finish ready counted", d0_ready, 1);
        repeat (10) drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("frozen ready_cnt", d0_ready, 1);
        check("frozen busy_cycles", d0_busy, 2);
        check("frozen done_cnt", d0_done, 0);
        check("frozen state", d0_state, 1);
        check("frozen finished", d0_fin, 1);
        do_reset();
        check("post-reset busy_cycles", d0_busy, 0);
        check("post-reset ready_cnt", d0_ready, 0);
        check("post-reset finished", d0_fin, 0);

        // Randomised traffic with occasional finish and reset.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(2, 0) == 0,
                  $urandom_range(1, 0) == 0,
                  $urandom_range(3, 0) == 0,
                  $urandom_range(2, 0) != 0,
                  $urandom_range(399, 0) == 0,
                  $urandom_range(199, 0) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_nodf_handshake_monitor
